// File: rtl/trivium_pkg.sv
// Trivium shared types, sizes and the single-step state update.
// Exports: state_t FSM enum, step_t, trivium_step(), trivium_load().
package trivium_pkg;

  localparam int KEY_W           = 80;
  localparam int IV_W            = 80;
  localparam int STATE_W         = 288;
  localparam int LD_WORDS        = 10;
  localparam int WARMUP_BITS_DEF = 1152;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WARMUP,
    READY,
    PROC,
    OUT
  } state_t;

  // s is the state after the step, z the keystream bit of the step
  typedef struct packed {
    logic [STATE_W-1:0] s;
    logic               z;
  } step_t;

  // Bit i of the packed state holds s(i+1) of the cipher description
  function automatic step_t trivium_step(
    input logic [STATE_W-1:0] s
  );
    step_t r;
    logic  t1;
    logic  t2;
    logic  t3;
    t1  = s[65] ^ s[92];
    t2  = s[161] ^ s[176];
    t3  = s[242] ^ s[287];
    r.z = t1 ^ t2 ^ t3;
    t1  = t1 ^ (s[90] & s[91]) ^ s[170];
    t2  = t2 ^ (s[174] & s[175]) ^ s[263];
    t3  = t3 ^ (s[285] & s[286]) ^ s[68];
    r.s = {s[286:177], t2,
           s[175:93], t1,
           s[91:0], t3};
    return r;
  endfunction

  // s1..s80 = K, s94..s173 = IV, s286..s288 = 1
  function automatic logic [STATE_W-1:0] trivium_load(
    input logic [KEY_W-1:0] key,
    input logic [IV_W-1:0]  iv
  );
    return {3'b111, 112'd0, iv, 13'd0, key};
  endfunction

endpackage

// File: rtl/trivium_core_nb.sv
// Trivium 288-bit state producing BPC keystream bits per enabled clock.
// Ports: clk_i, rst_i, load_i, en_i, key_i[80], iv_i[80], ks_o[BPC].
module trivium_core_nb
  import trivium_pkg::*;
#(
  parameter int BPC = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [KEY_W-1:0] key_i,
  input  logic [IV_W-1:0]  iv_i,
  output logic [BPC-1:0]   ks_o
);

  logic [STATE_W-1:0] st_q;
  logic [STATE_W-1:0] st_n;
  step_t              stp;

  // ks_o[j] is the keystream bit of the j-th unrolled step, so bit
  // order does not depend on BPC
  always_comb begin
    st_n = st_q;
    ks_o = '0;
    stp  = '0;
    for (int j = 0; j < BPC; j++) begin
      stp     = trivium_step(st_n);
      ks_o[j] = stp.z;
      st_n    = stp.s;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q <= '0;
    end else if (load_i) begin
      st_q <= trivium_load(key_i, iv_i);
    end else if (en_i) begin
      st_q <= st_n;
    end
  end

endmodule

// File: rtl/trivium_stream.sv
// Trivium stream controller: 16-bit key/IV load, warm-up, word XOR.
// Ports: clk_i/rst_i, ld_* load stream, init_i, dat_* in/out handshakes,
// busy_o; ks_o[DAT_W] only when TRIVIUM_KS_PORT_EN is defined.
module trivium_stream
  import trivium_pkg::*;
#(
  parameter int DAT_W       = 32,
  parameter int BPC         = 1,
  parameter int WARMUP_BITS = WARMUP_BITS_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [15:0]      ld_dat_i,
  input  logic             ld_vld_i,
  output logic             ld_rdy_o,
  input  logic             init_i,
  input  logic [DAT_W-1:0] dat_i,
  input  logic             dat_vld_i,
  output logic             dat_rdy_o,
  output logic [DAT_W-1:0] dat_o,
  output logic             dat_vld_o,
  input  logic             dat_rdy_i,
`ifdef TRIVIUM_KS_PORT_EN
  output logic [DAT_W-1:0] ks_o,
`endif
  output logic             busy_o
);

  localparam int WARM_CYC = WARMUP_BITS / BPC;
  localparam int PROC_CYC = DAT_W / BPC;
  localparam int CNT_W    = $clog2(WARM_CYC + 1);

  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARM_CYC - 1);
  localparam logic [CNT_W-1:0] PROC_LAST = CNT_W'(PROC_CYC - 1);
  localparam logic [3:0]       LD_FULL   = 4'(LD_WORDS);

  state_t                    state;
  state_t                    nxt;
  logic [CNT_W-1:0]          cnt;
  logic [3:0]                ld_cnt;
  logic [16*LD_WORDS-1:0]    ld_buf;
  logic [DAT_W-1:0]          dat_r;
  logic [BPC-1:0]            ks;
  logic                      init_go;
  logic                      core_load;
  logic                      core_en;

  assign init_go = init_i && (ld_cnt == LD_FULL);

  trivium_core_nb #(
    .BPC(BPC)
  ) u_core (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load_i(core_load),
    .en_i  (core_en),
    .key_i (ld_buf[KEY_W-1:0]),
    .iv_i  (ld_buf[KEY_W+IV_W-1:KEY_W]),
    .ks_o  (ks)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   if (init_go) nxt = LOAD;
      LOAD:   nxt = WARMUP;
      WARMUP: if (cnt == WARM_LAST) nxt = READY;
      READY: begin
        if (init_go) nxt = LOAD;
        else if (dat_vld_i) nxt = PROC;
      end
      PROC:   if (cnt == PROC_LAST) nxt = OUT;
      OUT:    if (dat_rdy_i) nxt = READY;
      default: nxt = IDLE;
    endcase
  end

  // init wins a tie with dat_vld_i, so ready drops when init fires
  always_comb begin
    ld_rdy_o  = !rst_i && (state == IDLE || state == READY)
                && (ld_cnt < LD_FULL);
    dat_rdy_o = !rst_i && (state == READY) && !init_go;
    dat_vld_o = !rst_i && (state == OUT);
    busy_o    = !rst_i && (state == LOAD || state == WARMUP
                || state == PROC);
    core_load = (state == LOAD);
    core_en   = (state == WARMUP) || (state == PROC);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || state != nxt) begin
      cnt <= '0;
    end else if (state == WARMUP || state == PROC) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ld_cnt <= '0;
      ld_buf <= '0;
      dat_r  <= '0;
      dat_o  <= '0;
    end else begin
      if (nxt == LOAD && state != LOAD) begin
        ld_cnt <= '0;
      end else if (ld_rdy_o && ld_vld_i) begin
        ld_buf[ld_cnt*16 +: 16] <= ld_dat_i;
        ld_cnt <= ld_cnt + 1'b1;
      end
      if (dat_rdy_o && dat_vld_i) begin
        dat_r <= dat_i;
      end
      if (state == PROC) begin
        dat_o[cnt*BPC +: BPC] <= dat_r[cnt*BPC +: BPC] ^ ks;
      end
    end
  end

`ifdef TRIVIUM_KS_PORT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ks_o <= '0;
    end else if (state == PROC) begin
      ks_o[cnt*BPC +: BPC] <= ks;
    end
  end
`endif

endmodule
